dmem_responder: RTL

- Memory-side responder for the pipeline's load/store interface. The core's MEM stage is the initiator; this block accepts its data-memory requests over a valid/ready handshake.
- Owns a byte-addressable, word-organised RAM and inserts a programmable number of wait states.
- Performs RV32I byte-lane steering and load sign/zero extension from funct3.
- Returns one response per request, with an error flag for misaligned, out-of-range or illegal accesses.

---
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with RV32I byte-lane steering and load extension.
// Latency: response valid 2+WAIT_STATES cycles after the accept cycle; one request in flight.
// Backpressure: req_ready low while busy; the response is held stable until rsp_ready.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] WS_LAST = 5'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_f3;

    logic [31:0] mem [DEPTH];

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_EXEC;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (({1'b0, cnt_q} + 5'd1) >= WS_LAST) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_f3    <= 3'd0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_f3    <= req_funct3;
        end
    end

    // ---------------- legality ----------------
    logic          in_range;
    logic          bad_code;
    logic          misalign;
    logic          access_err;
    logic [AW-1:0] word_idx;

    always_comb begin
        in_range = (lat_addr[31:2] < 30'(DEPTH));
        word_idx = lat_addr[AW+1:2];
        if (lat_we) begin
            bad_code = (lat_f3 > 3'b010);
        end else begin
            bad_code = (lat_f3 == 3'b011) || (lat_f3[2:1] == 2'b11);
        end
        // funct3[1:0] encodes access size for both B/BU, H/HU and W.
        misalign = ((lat_f3[1:0] == 2'b01) && lat_addr[0]) ||
                   ((lat_f3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
        access_err = !in_range || bad_code || misalign;
    end

    // ---------------- store lane steering ----------------
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    logic        do_store;

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = lat_wdata;
        case (lat_f3[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << lat_addr[1:0];
                wr_lanes = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                wr_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{lat_wdata[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = lat_wdata;
            end
        endcase
        do_store = (state_q == S_EXEC) && lat_we && !access_err;
    end

    // RAM has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // ---------------- load extraction ----------------
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    always_comb begin
        rd_word  = in_range ? mem[word_idx] : 32'd0;
        rd_shift = rd_word >> {lat_addr[1:0], 3'b000};
        case (lat_f3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = rd_word;
        endcase
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (state_q == S_EXEC) begin
            rsp_valid <= 1'b1;
            rsp_err   <= access_err;
            rsp_rdata <= (access_err || lat_we) ? 32'd0 : load_data;
        end else if ((state_q == S_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
